// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory handshake.
// Define MULTICYCLE_PERF_EN to build the cycle and instruction performance counters.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             readreg2_control,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             branch,
  output logic             unconditional_branch,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_CBZ  = 3'd4,
    CLS_B    = 3'd5
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d, cls_dec;

  always_comb begin
    casez (opcode)
      11'b11111000010: cls_dec = CLS_LD;
      11'b11111000000: cls_dec = CLS_ST;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls_dec = CLS_R;
      11'b10110100???: cls_dec = CLS_CBZ;
      11'b000101?????: cls_dec = CLS_B;
      default:         cls_dec = CLS_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (cls_dec == CLS_NONE) begin
          state_d = FETCH;
        end else begin
          state_d = EXEC;
          cls_d   = cls_dec;
        end
      end
      EXEC: begin
        case (cls_q)
          CLS_R:          state_d = WB;
          CLS_LD, CLS_ST: state_d = MEM;
          default:        state_d = FETCH;
        endcase
      end
      MEM:    if (mem_ready) state_d = (cls_q == CLS_LD) ? WB : FETCH;
      WB:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Outputs are gated by reset so an in-flight handshake drops in the same cycle.
  always_comb begin
    mem_req              = 1'b0;
    iord                 = 1'b0;
    ir_write             = 1'b0;
    pc_write             = 1'b0;
    readreg2_control     = 1'b0;
    alu_src              = 1'b0;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    mem_to_reg           = 1'b0;
    reg_write            = 1'b0;
    branch               = 1'b0;
    unconditional_branch = 1'b0;
    alu_op               = 2'b00;
    illegal              = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: illegal = (cls_dec == CLS_NONE);
        EXEC: begin
          case (cls_q)
            CLS_R:  alu_op = 2'b10;
            CLS_LD: alu_src = 1'b1;
            CLS_ST: begin
              alu_src          = 1'b1;
              readreg2_control = 1'b1;
            end
            CLS_CBZ: begin
              readreg2_control = 1'b1;
              alu_op           = 2'b01;
              branch           = 1'b1;
              pc_write         = zero;
            end
            CLS_B: begin
              unconditional_branch = 1'b1;
              pc_write             = 1'b1;
              alu_op               = 2'b01;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_read  = (cls_q == CLS_LD);
          mem_write = (cls_q == CLS_ST);
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == CLS_LD);
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             instr_done;

  always_comb begin
    instr_done    = (state_d == FETCH) &&
                    ((state_q == EXEC) || (state_q == MEM) || (state_q == WB));
    cycle_count_d = cycle_count_q + CNT_W'(1);
    instr_count_d = instr_done ? instr_count_q + CNT_W'(1) : instr_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors for each
// instruction class, handshake waits, illegal opcode, mid-handshake reset, counters.
module tb_multicycle_control;

  localparam int unsigned CNT_W = 32;

  // Packed control vector, MSB first:
  // mem_req iord ir_write pc_write rr2 alu_src mem_read mem_write mem_to_reg reg_write branch ub alu_op[1:0] illegal
  localparam logic [14:0] O_MREQ = 15'b100000000000000;
  localparam logic [14:0] O_IORD = 15'b010000000000000;
  localparam logic [14:0] O_IRW  = 15'b001000000000000;
  localparam logic [14:0] O_PCW  = 15'b000100000000000;
  localparam logic [14:0] O_RR2  = 15'b000010000000000;
  localparam logic [14:0] O_ASRC = 15'b000001000000000;
  localparam logic [14:0] O_MRD  = 15'b000000100000000;
  localparam logic [14:0] O_MWR  = 15'b000000010000000;
  localparam logic [14:0] O_M2R  = 15'b000000001000000;
  localparam logic [14:0] O_RW   = 15'b000000000100000;
  localparam logic [14:0] O_BR   = 15'b000000000010000;
  localparam logic [14:0] O_UB   = 15'b000000000001000;
  localparam logic [14:0] O_OP01 = 15'b000000000000010;
  localparam logic [14:0] O_OP10 = 15'b000000000000100;
  localparam logic [14:0] O_ILL  = 15'b000000000000001;

  localparam logic [14:0] V_FWAIT = O_MREQ | O_MRD;
  localparam logic [14:0] V_FDONE = O_MREQ | O_MRD | O_IRW | O_PCW;
  localparam logic [14:0] V_NONE  = 15'b0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100111;
  localparam logic [10:0] OP_B    = 11'b00010111111;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, iord, ir_write, pc_write, readreg2_control, alu_src;
  logic             mem_read, mem_write, mem_to_reg, reg_write, branch, unconditional_branch;
  logic [1:0]       alu_op;
  logic             illegal;
  logic [CNT_W-1:0] cycle_count, instr_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .opcode               (opcode),
    .zero                 (zero),
    .mem_ready            (mem_ready),
    .mem_req              (mem_req),
    .iord                 (iord),
    .ir_write             (ir_write),
    .pc_write             (pc_write),
    .readreg2_control     (readreg2_control),
    .alu_src              (alu_src),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_to_reg           (mem_to_reg),
    .reg_write            (reg_write),
    .branch               (branch),
    .unconditional_branch (unconditional_branch),
    .alu_op               (alu_op),
    .illegal              (illegal),
    .cycle_count          (cycle_count),
    .instr_count          (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ctl();
    return {mem_req, iord, ir_write, pc_write, readreg2_control, alu_src,
            mem_read, mem_write, mem_to_reg, reg_write, branch,
            unconditional_branch, alu_op, illegal};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, sample on the falling edge.
  task automatic cyc(input string tag, input logic [10:0] op, input logic rdy,
                     input logic z, input logic [14:0] exp);
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    check(tag, 64'(ctl()), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = OP_ADD;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    check("reset_outs", 64'(ctl()), 64'(V_NONE));
    check("reset_cycle_count", 64'(cycle_count), 64'd0);
    check("reset_instr_count", 64'(instr_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADD, zero-wait; mem_ready low in DECODE must be ignored.
    cyc("add_fetch",  OP_ADD, 1'b1, 1'b0, V_FDONE);
    cyc("add_decode", OP_ADD, 1'b0, 1'b0, V_NONE);
    cyc("add_exec",   OP_ADD, 1'b1, 1'b0, O_OP10);
    cyc("add_wb",     OP_ADD, 1'b0, 1'b0, O_RW);

    // LDUR with one FETCH wait and two MEM wait cycles.
    cyc("ld_fetch_wait", OP_LDUR, 1'b0, 1'b0, V_FWAIT);
    cyc("ld_fetch",      OP_LDUR, 1'b1, 1'b0, V_FDONE);
    cyc("ld_decode",     OP_LDUR, 1'b1, 1'b0, V_NONE);
    cyc("ld_exec",       OP_LDUR, 1'b0, 1'b0, O_ASRC);
    cyc("ld_mem_wait1",  OP_LDUR, 1'b0, 1'b0, O_MREQ | O_IORD | O_MRD);
    cyc("ld_mem_wait2",  OP_LDUR, 1'b0, 1'b0, O_MREQ | O_IORD | O_MRD);
    cyc("ld_mem_done",   OP_LDUR, 1'b1, 1'b0, O_MREQ | O_IORD | O_MRD);
    cyc("ld_wb",         OP_LDUR, 1'b1, 1'b0, O_RW | O_M2R);

    // STUR zero-wait returns straight to FETCH after MEM.
    cyc("st_fetch",  OP_STUR, 1'b1, 1'b0, V_FDONE);
    cyc("st_decode", OP_STUR, 1'b1, 1'b0, V_NONE);
    cyc("st_exec",   OP_STUR, 1'b1, 1'b0, O_ASRC | O_RR2);
    cyc("st_mem",    OP_STUR, 1'b1, 1'b0, O_MREQ | O_IORD | O_MWR);

    // CBZ taken; opcode changed in EXEC to confirm the latched class is used.
    cyc("cbz1_fetch",  OP_CBZ, 1'b1, 1'b0, V_FDONE);
    cyc("cbz1_decode", OP_CBZ, 1'b1, 1'b0, V_NONE);
    cyc("cbz1_exec",   OP_ADD, 1'b1, 1'b1, O_RR2 | O_OP01 | O_BR | O_PCW);
    // CBZ not taken.
    cyc("cbz0_fetch",  OP_CBZ, 1'b1, 1'b1, V_FDONE);
    cyc("cbz0_decode", OP_CBZ, 1'b1, 1'b1, V_NONE);
    cyc("cbz0_exec",   OP_CBZ, 1'b1, 1'b0, O_RR2 | O_OP01 | O_BR);

    // B
    cyc("b_fetch",  OP_B, 1'b1, 1'b0, V_FDONE);
    cyc("b_decode", OP_B, 1'b1, 1'b0, V_NONE);
    cyc("b_exec",   OP_B, 1'b1, 1'b0, O_UB | O_PCW | O_OP01);

    // Illegal opcode: single pulse in DECODE, then FETCH.
    cyc("ill_fetch",  OP_BAD, 1'b1, 1'b0, V_FDONE);
    cyc("ill_decode", OP_BAD, 1'b1, 1'b0, O_ILL);
    cyc("ill_after",  OP_BAD, 1'b0, 1'b0, V_FWAIT);
    cyc("ill_after2", OP_SUB, 1'b1, 1'b0, V_FDONE);
    cyc("sub_decode", OP_SUB, 1'b1, 1'b0, V_NONE);
    cyc("sub_exec",   OP_SUB, 1'b1, 1'b0, O_OP10);
    cyc("sub_wb",     OP_SUB, 1'b1, 1'b0, O_RW);

    // Reset in the middle of a STUR MEM wait.
    cyc("stw_fetch",  OP_STUR, 1'b1, 1'b0, V_FDONE);
    cyc("stw_decode", OP_STUR, 1'b1, 1'b0, V_NONE);
    cyc("stw_exec",   OP_STUR, 1'b1, 1'b0, O_ASRC | O_RR2);
    cyc("stw_mem_wait", OP_STUR, 1'b0, 1'b0, O_MREQ | O_IORD | O_MWR);
    #1;
    check("stw_mem_hold", 64'(ctl()), 64'(O_MREQ | O_IORD | O_MWR));
    reset = 1'b1;
    #1;
    check("rst_mid_outs", 64'(ctl()), 64'(V_NONE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("rst_fetch", OP_STUR, 1'b0, 1'b0, V_FWAIT);

    // Counters over ADD, B, STUR with zero wait states.
    do_reset();
    check("perf_clear_cycle", 64'(cycle_count), 64'd0);
    check("perf_clear_instr", 64'(instr_count), 64'd0);
    cyc("p_add_f", OP_ADD,  1'b1, 1'b0, V_FDONE);
    cyc("p_add_d", OP_ADD,  1'b1, 1'b0, V_NONE);
    cyc("p_add_e", OP_ADD,  1'b1, 1'b0, O_OP10);
    cyc("p_add_w", OP_ADD,  1'b1, 1'b0, O_RW);
    cyc("p_b_f",   OP_B,    1'b1, 1'b0, V_FDONE);
    cyc("p_b_d",   OP_B,    1'b1, 1'b0, V_NONE);
    cyc("p_b_e",   OP_B,    1'b1, 1'b0, O_UB | O_PCW | O_OP01);
    cyc("p_st_f",  OP_STUR, 1'b1, 1'b0, V_FDONE);
    cyc("p_st_d",  OP_STUR, 1'b1, 1'b0, V_NONE);
    cyc("p_st_e",  OP_STUR, 1'b1, 1'b0, O_ASRC | O_RR2);
    cyc("p_st_m",  OP_STUR, 1'b1, 1'b0, O_MREQ | O_IORD | O_MWR);
`ifdef MULTICYCLE_PERF_EN
    check("perf_cycle_count", 64'(cycle_count), 64'd11);
    check("perf_instr_count", 64'(instr_count), 64'd3);
`else
    check("perf_cycle_count", 64'(cycle_count), 64'd0);
    check("perf_instr_count", 64'(instr_count), 64'd0);
`endif
    cyc("p_next_f", OP_ADD, 1'b0, 1'b0, V_FWAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  11  instruction[31:21] from the external instruction register; valid from DECODE onward.
REQ-005 SHALL have port zero  input  1  ALU zero flag; sampled in EXEC.
REQ-006 SHALL have port mem_ready  input  1  memory handshake completion.
REQ-007 SHALL have outputs mem_req, iord, ir_write, pc_write, readreg2_control, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, unconditional_branch, 1 bit each.
REQ-008 SHALL have output alu_op  2  ALU operation class (00 add, 01 pass/zero-test, 10 funct-decoded).
REQ-009 SHALL have output illegal  1  one-cycle pulse on an unrecognised opcode.
REQ-010 SHALL have outputs cycle_count and instr_count, CNT_W bits each.

Function
REQ-011 SHALL implement the states FETCH, DECODE, EXEC, MEM and WB.
REQ-012 SHALL decode: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100xxx, B 000101xxxxx.
REQ-013 SHALL latch the decoded instruction class on the DECODE-to-EXEC transition and use only the latched class in EXEC, MEM and WB.
REQ-014 FETCH: mem_req=1, mem_read=1, iord=0; holds while mem_ready=0; on mem_ready=1 asserts ir_write=1 and pc_write=1 (PC+4) in the same cycle, then moves to DECODE.
REQ-015 DECODE: all write strobes 0; one cycle; moves to EXEC, or to FETCH with illegal=1 for an unrecognised opcode.
REQ-016 EXEC, R-type: alu_op=10, alu_src=0, then WB.
REQ-017 EXEC, LDUR/STUR: alu_op=00, alu_src=1, readreg2_control=1 for STUR, then MEM.
REQ-018 EXEC, CBZ: readreg2_control=1, alu_op=01, branch=1, pc_write=zero, then FETCH.
REQ-019 EXEC, B: unconditional_branch=1, pc_write=1, alu_op=01, then FETCH.
REQ-020 MEM: mem_req=1, iord=1, with mem_read=1 for LDUR or mem_write=1 for STUR; holds until mem_ready=1; then WB for LDUR, FETCH for STUR.
REQ-021 WB: reg_write=1, mem_to_reg=1 for LDUR else 0, then FETCH.
REQ-022 SHALL hold mem_req, mem_read and mem_write stable through every wait cycle, and SHALL ignore mem_ready outside FETCH and MEM.
REQ-023 SHALL produce all outputs combinationally from state, the latched class, mem_ready and zero; every output not named for a state SHALL be 0.
REQ-024 Zero-wait latency SHALL be: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3, illegal 2.

Reset
REQ-025 Reset assertion SHALL force FETCH, clear the latched class, and drive every strobe and alu_op to 0 immediately, including mid-handshake.
REQ-026 The first FETCH SHALL start on the first rising edge after reset deasserts.

Configuration
REQ-027 With MULTICYCLE_PERF_EN defined, cycle_count SHALL increment on every clock and instr_count SHALL increment on each transition into FETCH from EXEC, MEM or WB; both SHALL wrap at 2^CNT_W and clear on reset.
REQ-028 Without MULTICYCLE_PERF_EN, cycle_count and instr_count SHALL be tied to 0 and the counter logic SHALL NOT be compiled.

Verification
REQ-029 ADD (8B09026A), mem_ready=1 -> states FETCH,DECODE,EXEC,WB; reg_write=1 only in WB; alu_op=10 in EXEC.
REQ-030 LDUR (F84402C9) with mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles, mem_read and iord held high, then WB with mem_to_reg=1.
REQ-031 CBZ (B4FFFF6B): zero=1 -> pc_write=1 in EXEC; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-032 Opcode 11111111111 -> illegal pulses once in DECODE, no write strobe asserted, FETCH next.
REQ-033 Reset asserted mid-STUR MEM wait -> mem_write and mem_req drop within the same cycle; FETCH follows reset release.
REQ-034 With MULTICYCLE_PERF_EN, ADD, B and STUR run with mem_ready=1 -> instr_count=3 and cycle_count=11.
